jpeg_block_sequencer: RTL and testbench
=======================================

# jpeg_block_sequencer

Control sequencer for the three-channel JPEG encoder top. It accepts a stream of RGB pixels over a valid/ready handshake, gathers one 8x8 block (64 pixels), then drives the encoder phase controls in order: pixel load, DCT, DCT end, zigzag load, Huffman start. It waits for all three channel encoders (Y, Cb, Cr) to report completion before accepting the next block. It sits between the pixel source and the encoder top and replaces the hand-driven phase controls used in bring-up benches.

## Interface
- RGB_LAT, 1: cycles from `Red/Green/Blue` registered out to valid YCbCr at encoder input; range 1-4.
- DCT_CYCLES, 8: cycles `dct_enable` is held high; range 1-255.
- ZZ_WAIT, 2: idle cycles after `zigzag_input_enable` pulse before `Huffman_start`; range 0-255.
- HUFF_TIMEOUT, 1024: max cycles waiting for channel completion; range 1-65535.

- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin block processing; sampled in IDLE only
- abort  in  1  synchronous return to IDLE from any state
- pix_valid  in  1  source has a pixel
- pix_r, pix_g, pix_b  in  8 each  source pixel
- pix_ready  out  1  sequencer accepts pixel this cycle
- Red, Green, Blue  out  8 each  registered pixel to encoder top
- input_enable  out  1  high during block load and drain
- input_1pix_enable  out  1  one pulse per pixel, aligned to converter output
- dct_enable  out  1  DCT phase level
- dct_end_enable  out  1  one-cycle pulse after DCT
- zigzag_input_enable  out  1  one-cycle pulse
- Huffman_start  out  1  one-cycle pulse
- y_done, cb_done, cr_done  in  1 each  channel completion pulses
- block_done  out  1  one-cycle pulse, block finished
- timeout_err  out  1  sticky; cleared by `start` in IDLE or reset
- block_count  out  16  completed blocks, wraps 0xFFFF->0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, DRAIN, DCT, DCT_END, ZIGZAG, ZZ_WAIT, HUFF, DONE.
- IDLE: `start`=1 -> LOAD; clear pixel counter, `timeout_err`.
- LOAD: `pix_ready`=1 while pixel counter (7 bits) < 64. Accept = `pix_valid & pix_ready`; on accept register pix_* into `Red/Green/Blue`, increment counter, push 1 into RGB_LAT+1-deep valid shift register (0 otherwise). Counter reaches 64 -> DRAIN; `pix_ready` deasserts the same cycle the 64th pixel is accepted.
- `input_1pix_enable` = tail of the shift register: exactly RGB_LAT+1 cycles after the accepting edge. Gaps in `pix_valid` propagate as gaps.
- DRAIN: wait until shift register is all zero -> DCT. Exactly 64 `input_1pix_enable` pulses per block.
- `input_enable` = 1 in LOAD and DRAIN.
- DCT: `dct_enable`=1 for DCT_CYCLES cycles -> DCT_END (one cycle, `dct_end_enable`=1) -> ZIGZAG (one cycle, `zigzag_input_enable`=1) -> ZZ_WAIT for ZZ_WAIT cycles (skipped if 0) -> HUFF.
- HUFF: `Huffman_start`=1 on first cycle only. Capture `*_done` into three sticky flags (flags cleared on HUFF entry; a done on the entry cycle is captured). All three set -> DONE. Timer reaches HUFF_TIMEOUT -> set `timeout_err`, -> DONE.
- DONE: one cycle, `block_done`=1, `block_count`+1 -> LOAD (continuous operation; IDLE only via `abort`).
- `abort`: highest priority, any state -> IDLE next edge; clears shift register, counters, done flags; all phase outputs 0 next cycle; `block_count` and `timeout_err` retained.
- `start` outside IDLE ignored.

## Timing
- Reset: state IDLE; all outputs 0 (`Red/Green/Blue`=0, `block_count`=0, `timeout_err`=0, `pix_ready`=0).
- Reset mid-block: everything returns to reset values asynchronously; no partial pulses after release.
- All outputs registered or decoded from registered state; no combinational path from `pix_valid` to `pix_ready`.
- Minimum block time with no stalls: 1 (IDLE->LOAD) + 64 + (RGB_LAT+1) + DCT_CYCLES + 1 + 1 + ZZ_WAIT + HUFF wait + 1.
- `dct_enable` rises the cycle after last `input_1pix_enable`.
- Pulses `dct_end_enable`, `zigzag_input_enable`, `Huffman_start`, `block_done` are exactly one cycle wide and never overlap.
- Done pulses outside HUFF are ignored.

## Test plan
- Streaming block, defaults, `pix_valid` tied 1: 64 accepts in 64 cycles; 64 `input_1pix_enable` pulses each 2 cycles after accept; `dct_enable` high 8 cycles; dones at HUFF+5 -> one `block_done`, `block_count`=1.
- Stalled source (`pix_valid` toggles 1,0): 64 accepts over 128 cycles; pulse gaps mirror stalls; `pix_ready`=0 after 64th accept.
- Done ordering: cr_done, then y_done 3 cycles later, cb_done on HUFF entry cycle -> DONE after last; done outside HUFF ignored.
- Timeout: HUFF_TIMEOUT=16, only y_done -> `timeout_err`=1 after 16 cycles, `block_done` pulses, next block proceeds; `start` in IDLE after abort clears it.
- Abort in DCT cycle 3 and reset_n low in LOAD after 30 pixels: next edge/asynchronously all phase outputs 0, IDLE; next `start` collects a full fresh 64 pixels.
- Back-to-back 3 blocks, RGB_LAT=3, ZZ_WAIT=0: `block_count`=3; `Huffman_start` immediately after `zigzag_input_enable`; pulse alignment 4 cycles after accept.

Source files
------------

// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_block_sequencer
// Purpose  : Phase sequencer for the three-channel JPEG encoder top. Gathers
//            one 8x8 RGB block over a valid/ready handshake, then steps the
//            encoder through DCT, DCT end, zigzag load and Huffman start, and
//            waits for the Y/Cb/Cr encoders to finish before the next block.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer #(
  parameter int RGB_LAT      = 1,
  parameter int DCT_CYCLES   = 8,
  parameter int ZZ_WAIT      = 2,
  parameter int HUFF_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_pix_r,
  input  logic [7:0]  i_pix_g,
  input  logic [7:0]  i_pix_b,
  output logic        o_pix_ready,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_input_enable,
  output logic        o_input_1pix_enable,
  output logic        o_dct_enable,
  output logic        o_dct_end_enable,
  output logic        o_zigzag_input_enable,
  output logic        o_huffman_start,
  input  logic        i_y_done,
  input  logic        i_cb_done,
  input  logic        i_cr_done,
  output logic        o_block_done,
  output logic        o_timeout_err,
  output logic [15:0] o_block_count,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_DRAIN   = 4'd2,
    S_DCT     = 4'd3,
    S_DCT_END = 4'd4,
    S_ZIGZAG  = 4'd5,
    S_ZZ_WAIT = 4'd6,
    S_HUFF    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [6:0]  c_PIX_LAST  = 7'd63;
  localparam logic [7:0]  c_DCT_LAST  = 8'(DCT_CYCLES - 1);
  localparam logic [7:0]  c_ZZ_LAST   = (ZZ_WAIT > 0) ? 8'(ZZ_WAIT - 1) : 8'd0;
  localparam logic [15:0] c_HUFF_LAST = 16'(HUFF_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [6:0]       r_pix_cnt;
  logic [RGB_LAT:0] r_vld_sr;
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic [7:0]       r_blue;
  logic [7:0]       r_phase_cnt;
  logic [15:0]      r_huff_timer;
  logic [2:0]       r_done_flags;
  logic             r_timeout_err;
  logic [15:0]      r_block_count;

  logic             w_pix_ready;
  logic             w_accept;
  logic             w_drain_empty;
  logic             w_state_change;
  logic [2:0]       w_done_seen;
  logic             w_all_done;
  logic             w_huff_tmo;

  // Ready depends only on registered state so pix_valid never loops back to pix_ready.
  assign w_pix_ready    = (r_state == S_LOAD) && !r_pix_cnt[6];
  assign w_accept       = w_pix_ready && i_pix_valid && !i_abort;
  // DRAIN shifts in zeros, so the register empties next edge when only the tail is set.
  assign w_drain_empty  = (r_vld_sr[RGB_LAT-1:0] == '0);
  assign w_done_seen    = r_done_flags | {i_cr_done, i_cb_done, i_y_done};
  assign w_all_done     = &w_done_seen;
  assign w_huff_tmo     = (r_huff_timer == c_HUFF_LAST);
  assign w_state_change = (w_state_next != r_state);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection and phase-control decode from the registered state.
  always_comb begin
    w_state_next          = r_state;
    o_pix_ready           = w_pix_ready;
    o_input_enable        = 1'b0;
    o_input_1pix_enable   = r_vld_sr[RGB_LAT];
    o_dct_enable          = 1'b0;
    o_dct_end_enable      = 1'b0;
    o_zigzag_input_enable = 1'b0;
    o_huffman_start       = 1'b0;
    o_block_done          = 1'b0;
    o_busy                = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        o_input_enable = 1'b1;
        if (w_accept && (r_pix_cnt == c_PIX_LAST)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_input_enable = 1'b1;
        if (w_drain_empty) begin
          w_state_next = S_DCT;
        end
      end
      S_DCT: begin
        o_dct_enable = 1'b1;
        if (r_phase_cnt == c_DCT_LAST) begin
          w_state_next = S_DCT_END;
        end
      end
      S_DCT_END: begin
        o_dct_end_enable = 1'b1;
        w_state_next     = S_ZIGZAG;
      end
      S_ZIGZAG: begin
        o_zigzag_input_enable = 1'b1;
        w_state_next          = (ZZ_WAIT == 0) ? S_HUFF : S_ZZ_WAIT;
      end
      S_ZZ_WAIT: begin
        if (r_phase_cnt == c_ZZ_LAST) begin
          w_state_next = S_HUFF;
        end
      end
      S_HUFF: begin
        o_huffman_start = (r_huff_timer == 16'd0);
        if (w_all_done || w_huff_tmo) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_block_done = 1'b1;
        w_state_next = S_LOAD;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (i_abort) begin
      w_state_next = S_IDLE;
    end
  end

  // Pixel counter: restarts whenever a new block load is about to begin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (i_abort || (r_state == S_IDLE) || (r_state == S_DONE)) begin
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      r_pix_cnt <= r_pix_cnt + 7'd1;
    end
  end

  // Converter-latency tracker: one bit per accepted pixel, tail drives the per-pixel strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else if (i_abort) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr <= {r_vld_sr[RGB_LAT-1:0], w_accept};
    end
  end

  // Pixel output register, loaded only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (w_accept) begin
      r_red   <= i_pix_r;
      r_green <= i_pix_g;
      r_blue  <= i_pix_b;
    end
  end

  // Dwell counter for DCT and zigzag-wait phases; zeroed on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_cnt <= '0;
    end else if (w_state_change) begin
      r_phase_cnt <= '0;
    end else if ((r_state == S_DCT) || (r_state == S_ZZ_WAIT)) begin
      r_phase_cnt <= r_phase_cnt + 8'd1;
    end
  end

  // Huffman wait timer and sticky completion flags; both start clean on HUFF entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_huff_timer <= '0;
      r_done_flags <= '0;
    end else if ((r_state == S_HUFF) && !w_state_change) begin
      r_huff_timer <= r_huff_timer + 16'd1;
      r_done_flags <= w_done_seen;
    end else begin
      r_huff_timer <= '0;
      r_done_flags <= '0;
    end
  end

  // Sticky timeout flag: set when HUFF expires without all channels, cleared by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (!i_abort) begin
      if ((r_state == S_IDLE) && i_start) begin
        r_timeout_err <= 1'b0;
      end else if ((r_state == S_HUFF) && w_huff_tmo && !w_all_done) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Completed-block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_block_count <= '0;
    end else if (!i_abort && (r_state == S_DONE)) begin
      r_block_count <= r_block_count + 16'd1;
    end
  end

  assign o_red         = r_red;
  assign o_green       = r_green;
  assign o_blue        = r_blue;
  assign o_timeout_err = r_timeout_err;
  assign o_block_count = r_block_count;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_block_sequencer
// Purpose  : Randomized bench for jpeg_block_sequencer against a timeline
//            model that predicts every output from event times (accepts,
//            last strobe, Huffman window) rather than from FSM states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_block_sequencer;

  localparam int P_LAT = 2;
  localparam int P_DCT = 6;
  localparam int P_ZZ  = 2;
  localparam int P_TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0, i_pix_valid = 1'b0;
  logic [7:0]  i_pix_r = '0, i_pix_g = '0, i_pix_b = '0;
  logic        i_y_done = 1'b0, i_cb_done = 1'b0, i_cr_done = 1'b0;
  logic        o_pix_ready, o_input_enable, o_input_1pix_enable;
  logic        o_dct_enable, o_dct_end_enable, o_zigzag_input_enable;
  logic        o_huffman_start, o_block_done, o_timeout_err, o_busy;
  logic [7:0]  o_red, o_green, o_blue;
  logic [15:0] o_block_count;

  always #5 clk = ~clk;

  jpeg_block_sequencer #(
    .RGB_LAT(P_LAT), .DCT_CYCLES(P_DCT), .ZZ_WAIT(P_ZZ), .HUFF_TIMEOUT(P_TMO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_pix_valid(i_pix_valid), .i_pix_r(i_pix_r), .i_pix_g(i_pix_g), .i_pix_b(i_pix_b),
    .o_pix_ready(o_pix_ready), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_input_enable(o_input_enable), .o_input_1pix_enable(o_input_1pix_enable),
    .o_dct_enable(o_dct_enable), .o_dct_end_enable(o_dct_end_enable),
    .o_zigzag_input_enable(o_zigzag_input_enable), .o_huffman_start(o_huffman_start),
    .i_y_done(i_y_done), .i_cb_done(i_cb_done), .i_cr_done(i_cr_done),
    .o_block_done(o_block_done), .o_timeout_err(o_timeout_err),
    .o_block_count(o_block_count), .o_busy(o_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: event times in cycle numbers, -1 when not pending.
  bit          m_idle, m_loading, m_inen, m_terr;
  int          m_acc;
  int          q_pulse[$];
  logic [7:0]  m_r, m_g, m_b;
  logic [15:0] m_count;
  int          t_lp, t_hwin, t_bd;
  bit [2:0]    m_flags;

  // Stimulus knobs.
  int vmode = 0;
  int done_pct = 25;
  bit cr_off = 1'b0;
  int abort_rate = 0;
  int start_rate = 0;
  bit force_start = 1'b0;
  bit force_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_abort();
    m_idle = 1'b1; m_loading = 1'b0; m_inen = 1'b0; m_acc = 0;
    q_pulse.delete();
    t_lp = -1; t_hwin = -1; t_bd = -1; m_flags = '0;
  endtask

  task automatic model_reset();
    model_abort();
    m_r = '0; m_g = '0; m_b = '0; m_count = '0; m_terr = 1'b0;
  endtask

  // Advance the model over the edge that ends cycle c.
  task automatic model_step(input int c);
    bit was_idle, was_loading;
    was_idle    = m_idle;
    was_loading = m_loading;
    if (!rst_n) begin
      model_reset();
    end else if (i_abort) begin
      model_abort();
    end else begin
      if (was_idle && i_start) begin
        m_idle = 1'b0; m_loading = 1'b1; m_inen = 1'b1; m_acc = 0; m_terr = 1'b0;
      end
      if (was_loading && i_pix_valid) begin
        q_pulse.push_back(c + P_LAT + 1);
        m_r = i_pix_r; m_g = i_pix_g; m_b = i_pix_b;
        m_acc++;
        if (m_acc == 64) begin
          m_loading = 1'b0;
          t_lp      = c + P_LAT + 1;
          t_hwin    = t_lp + P_DCT + 3 + P_ZZ;
          m_flags   = '0;
        end
      end
      if (t_hwin >= 0 && c >= t_hwin) begin
        m_flags = m_flags | {i_cr_done, i_cb_done, i_y_done};
        if (&m_flags) begin
          t_bd = c + 1; t_hwin = -1;
        end else if (c == t_hwin + P_TMO - 1) begin
          m_terr = 1'b1; t_bd = c + 1; t_hwin = -1;
        end
      end
      if (t_bd >= 0 && c == t_bd) begin
        m_count = m_count + 16'd1;
        m_loading = 1'b1; m_inen = 1'b1; m_acc = 0; t_bd = -1;
      end
      if (t_lp >= 0 && c == t_lp) m_inen = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit e1;
    e1 = 1'b0;
    if (q_pulse.size() > 0 && q_pulse[0] == cyc) begin
      e1 = 1'b1;
      void'(q_pulse.pop_front());
    end
    check("busy",        32'(o_busy),                32'(!m_idle));
    check("pix_ready",   32'(o_pix_ready),           32'(m_loading));
    check("input_en",    32'(o_input_enable),        32'(m_inen));
    check("pix_strobe",  32'(o_input_1pix_enable),   32'(e1));
    check("dct_en",      32'(o_dct_enable),
          32'(t_lp >= 0 && cyc > t_lp && cyc <= t_lp + P_DCT));
    check("dct_end",     32'(o_dct_end_enable),      32'(t_lp >= 0 && cyc == t_lp + P_DCT + 1));
    check("zigzag",      32'(o_zigzag_input_enable), 32'(t_lp >= 0 && cyc == t_lp + P_DCT + 2));
    check("huff_start",  32'(o_huffman_start),
          32'(t_lp >= 0 && cyc == t_lp + P_DCT + 3 + P_ZZ));
    check("block_done",  32'(o_block_done),          32'(t_bd >= 0 && cyc == t_bd));
    check("timeout_err", 32'(o_timeout_err),         32'(m_terr));
    check("block_count", 32'(o_block_count),         32'(m_count));
    check("red",         32'(o_red),                 32'(m_r));
    check("green",       32'(o_green),               32'(m_g));
    check("blue",        32'(o_blue),                32'(m_b));
  endtask

  task automatic drive_inputs();
    case (vmode)
      0:       i_pix_valid = 1'b1;
      1:       i_pix_valid = ((cyc % 2) == 0);
      default: i_pix_valid = ($urandom_range(0, 1) == 1);
    endcase
    i_pix_r   = 8'($urandom_range(0, 255));
    i_pix_g   = 8'($urandom_range(0, 255));
    i_pix_b   = 8'($urandom_range(0, 255));
    i_y_done  = ($urandom_range(0, 99) < done_pct);
    i_cb_done = ($urandom_range(0, 99) < done_pct);
    i_cr_done = !cr_off && ($urandom_range(0, 99) < done_pct);
    i_start   = force_start || (start_rate != 0 && $urandom_range(0, start_rate - 1) == 0);
    i_abort   = force_abort || (abort_rate != 0 && $urandom_range(0, abort_rate - 1) == 0);
    force_start = 1'b0;
    force_abort = 1'b0;
  endtask

  // One cycle: drive just after the edge, check mid-cycle, advance the model at the edge.
  task automatic run1();
    drive_inputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step(cyc);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run1();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int budget;
    model_reset();
    @(posedge clk);
    #1;
    // Held in reset: all outputs at reset values.
    run(3);
    rst_n = 1'b1;
    run(2);

    // Streaming source, random completion times.
    vmode = 0; done_pct = 25; force_start = 1'b1;
    run(700);

    // Abort on the third DCT cycle.
    start_rate = 0;
    budget = 1000;
    while (!(t_lp >= 0 && cyc == t_lp + 3) && budget > 0) begin run1(); budget--; end
    check("wait_dct3", 32'(budget > 0), 32'd1);
    force_abort = 1'b1;
    run(10);

    // Alternating-valid source.
    vmode = 1; done_pct = 20; force_start = 1'b1;
    run(600);

    // Asynchronous reset in the middle of a load, 30 pixels in.
    vmode = 2;
    budget = 1000;
    while (!(m_loading && m_acc == 30) && budget > 0) begin run1(); budget--; end
    check("wait_pix30", 32'(budget > 0), 32'd1);
    rst_n = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(2);
    force_start = 1'b1;

    // Cr never completes: every block times out, then abort and restart clear it.
    cr_off = 1'b1; done_pct = 30;
    run(500);
    force_abort = 1'b1;
    run(5);
    force_start = 1'b1;
    run(5);
    cr_off = 1'b0;
    run(300);

    // Fully random traffic including stray starts and occasional aborts.
    done_pct = 15; abort_rate = 300; start_rate = 20;
    run(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
